// File: rtl/fft_frame_ctrl_pkg.sv
// Shared sizing, FSM encoding and tag type for the fft frame sequencer.
package fft_frame_ctrl_pkg;
    localparam int N          = 64;
    localparam int LOG2N      = 6;
    localparam int DW         = 34;
    localparam int LAT        = 72;
    localparam int INFLIGHT_W = $clog2(LAT + 2);

    typedef enum logic {
        IDLE = 1'b0,
        LOAD = 1'b1
    } state_t;

    typedef struct packed {
        logic v;
        logic sop;
        logic eop;
    } tag_t;
endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Input sample handshake and tagged result stream of the fft frame sequencer.
interface fft_frame_ctrl_if import fft_frame_ctrl_pkg::*; ();
    logic [DW-1:0]    in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic             out_sop;
    logic             out_eop;
    logic [LOG2N-1:0] out_index;

    modport slave (
        input  in_data, in_valid,
        output in_ready, out_data, out_valid, out_sop, out_eop, out_index
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, out_data, out_valid, out_sop, out_eop, out_index
    );
endinterface

// File: rtl/fft_tag_delay.sv
// Fixed-depth shift register carrying {v,sop,eop} alongside the fft core pipeline.
module fft_tag_delay import fft_frame_ctrl_pkg::*; #(
    parameter int DEPTH = LAT
) (
    input  logic clk,
    input  logic rst,
    input  tag_t tag_in,
    output tag_t tag_out
);
    tag_t [DEPTH-1:0] pipe_reg;

    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pipe_reg <= '0;
                else     pipe_reg <= tag_in;
            end
        end else begin : g_chain
            always_ff @(posedge clk or posedge rst) begin
                if (rst) pipe_reg <= '0;
                else     pipe_reg <= {pipe_reg[DEPTH-2:0], tag_in};
            end
        end
    endgenerate

    assign tag_out = pipe_reg[DEPTH-1];
endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: feeds the free-running fft core one slot per clk and tags its output.
module fft_frame_ctrl import fft_frame_ctrl_pkg::*; (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fft_frame_ctrl_if.slave      io,
    output logic [DW-1:0]        core_din,
    input  logic [DW-1:0]        core_dout,
    output logic                 underrun,
    input  logic                 err_clr,
    output logic                 busy,
    output logic [15:0]          frame_cnt
);
    state_t                 state_reg;
    logic [LOG2N-1:0]       cnt_reg;
    logic                   underrun_reg;
    logic [INFLIGHT_W-1:0]  inflight_reg;
    logic [DW-1:0]          out_data_reg;
    logic                   out_valid_reg;
    logic                   out_sop_reg;
    logic                   out_eop_reg;
    logic [LOG2N-1:0]       out_index_reg;
    logic [15:0]            frame_cnt_reg;

    logic accept;
    logic slot_v;
    logic last_slot;
    tag_t tag_in;
    tag_t tag_dly;

    // Mid-frame the core must get a slot every cycle, so enable only gates frame start.
    assign io.in_ready = ~rst & ((state_reg == LOAD) | enable);
    assign accept      = io.in_valid & io.in_ready;
    assign slot_v      = (state_reg == LOAD) | accept;
    assign last_slot   = (state_reg == LOAD) && (cnt_reg == LOG2N'(N - 1));
    assign core_din    = (slot_v & io.in_valid) ? io.in_data : '0;
    assign tag_in      = {slot_v, (state_reg == IDLE) & accept, last_slot};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg <= LOAD;
                        cnt_reg   <= LOG2N'(1);
                    end
                end
                LOAD: begin
                    cnt_reg <= cnt_reg + LOG2N'(1);
                    if (last_slot) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                        underrun_reg <= 1'b0;
        else if ((state_reg == LOAD) && !io.in_valid)   underrun_reg <= 1'b1;
        else if (err_clr)                               underrun_reg <= 1'b0;
    end

    fft_tag_delay #(.DEPTH(LAT)) u_tag_delay (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_dly)
    );

    // Slots without a valid tag are idle feed; their core output is dropped here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_sop_reg   <= 1'b0;
            out_eop_reg   <= 1'b0;
            out_index_reg <= '0;
            frame_cnt_reg <= '0;
            inflight_reg  <= '0;
        end else begin
            out_valid_reg <= tag_dly.v;
            out_sop_reg   <= tag_dly.v & tag_dly.sop;
            out_eop_reg   <= tag_dly.v & tag_dly.eop;
            out_data_reg  <= tag_dly.v ? core_dout : '0;
            if (tag_dly.v)
                out_index_reg <= tag_dly.sop ? '0 : out_index_reg + LOG2N'(1);
            if (out_valid_reg & out_eop_reg)
                frame_cnt_reg <= frame_cnt_reg + 16'd1;
            inflight_reg <= inflight_reg + INFLIGHT_W'(slot_v) - INFLIGHT_W'(out_valid_reg);
        end
    end

    assign io.out_data  = out_data_reg;
    assign io.out_valid = out_valid_reg;
    assign io.out_sop   = out_sop_reg;
    assign io.out_eop   = out_eop_reg;
    assign io.out_index = out_index_reg;
    assign underrun     = underrun_reg;
    assign frame_cnt    = frame_cnt_reg;
    assign busy         = (state_reg == LOAD) | (inflight_reg != '0);
endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with the fft core modelled as a pure LAT-cycle delay.
module tb_fft_frame_ctrl;
    import fft_frame_ctrl_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            enable = 1'b0;
    logic            err_clr = 1'b0;
    logic [DW-1:0]   core_din;
    logic [DW-1:0]   core_dout;
    logic            underrun;
    logic            busy;
    logic [15:0]     frame_cnt;
    int              cyc = 0;
    int              n_checks = 0;
    int              n_pass = 0;

    fft_frame_ctrl_if bus ();

    fft_frame_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .io        (bus),
        .core_din  (core_din),
        .core_dout (core_dout),
        .underrun  (underrun),
        .err_clr   (err_clr),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core model: unaffected by rst, like the real core.
    logic [DW-1:0] core_pipe [LAT];
    initial for (int i = 0; i < LAT; i++) core_pipe[i] = '0;
    always @(posedge clk) begin
        for (int i = LAT - 1; i > 0; i--) core_pipe[i] <= core_pipe[i-1];
        core_pipe[0] <= core_din;
    end
    assign core_dout = core_pipe[LAT-1];

    typedef struct {
        logic [DW-1:0]    data;
        logic             sop;
        logic             eop;
        logic [LOG2N-1:0] idx;
        int               cyc;
    } out_rec_t;
    out_rec_t q[$];

    always @(negedge clk) begin
        if (bus.out_valid) begin
            q.push_back('{bus.out_data, bus.out_sop, bus.out_eop, bus.out_index, cyc});
            if (bus.out_eop) $display("out frame end: cyc %0d frame_cnt %0d", cyc, frame_cnt);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.in_valid = 1'b0;
        err_clr = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        q.delete();
    endtask

    // Drives sample k = in_data k+1; gap range drops in_valid, enable low from en_off on.
    task automatic run_samples(input string name, input int count, input int frames,
                               input int gap_lo, input int gap_hi, input int en_off,
                               input int clr_at, output int t0);
        logic [DW-1:0] exp_din;
        logic          gap;
        t0 = 0;
        for (int k = 0; k < count; k++) begin
            @(negedge clk);
            if (k == 0) t0 = cyc;
            gap = (k >= gap_lo) && (k <= gap_hi);
            bus.in_valid = !gap;
            bus.in_data  = DW'(k + 1);
            enable       = (k < en_off);
            err_clr      = (k == clr_at);
            #1;
            exp_din = (k < frames * N && !gap) ? DW'(k + 1) : '0;
            chk($sformatf("%s_in_ready[%0d]", name, k), bus.in_ready, (k < frames * N) ? 1 : 0);
            chk($sformatf("%s_core_din[%0d]", name, k), core_din, exp_din);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, busy, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_frame(input string name, input int qstart, input int base,
                               input int first_cyc, input int zlo, input int zhi);
        out_rec_t r;
        logic [DW-1:0] exp_d;
        if (q.size() < qstart + N) begin
            chk({name, "_nout"}, q.size(), qstart + N);
            return;
        end
        for (int j = 0; j < N; j++) begin
            r = q[qstart + j];
            exp_d = (j >= zlo && j <= zhi) ? '0 : DW'(base + j + 1);
            chk($sformatf("%s_data[%0d]", name, j), r.data, exp_d);
            chk($sformatf("%s_index[%0d]", name, j), r.idx, j);
            chk($sformatf("%s_sop[%0d]", name, j), r.sop, (j == 0) ? 1 : 0);
            chk($sformatf("%s_eop[%0d]", name, j), r.eop, (j == N - 1) ? 1 : 0);
            chk($sformatf("%s_cyc[%0d]", name, j), r.cyc, first_cyc + j);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int bad;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_frame_cnt", frame_cnt, 0);
        chk("rst_core_din", core_din, 0);

        // 1: single frame
        do_reset();
        run_samples("t1", N, 1, -1, -1, 1000, -1, t0);
        chk("t1_busy_inflight", busy, 1);
        wait_idle("t1", 300);
        chk("t1_nout", q.size(), N);
        check_frame("t1", 0, 0, t0 + LAT + 1, -1, -1);
        chk("t1_frame_cnt", frame_cnt, 1);
        chk("t1_underrun", underrun, 0);

        // 2: back-to-back frames
        do_reset();
        run_samples("t2", 2 * N, 2, -1, -1, 1000, -1, t0);
        wait_idle("t2", 300);
        chk("t2_nout", q.size(), 2 * N);
        check_frame("t2a", 0, 0, t0 + LAT + 1, -1, -1);
        check_frame("t2b", N, N, t0 + LAT + 1 + N, -1, -1);
        chk("t2_frame_cnt", frame_cnt, 2);

        // 3: gap at samples 10..12, then clear
        do_reset();
        run_samples("t3", N, 1, 10, 12, 1000, -1, t0);
        chk("t3_underrun_set", underrun, 1);
        wait_idle("t3", 300);
        chk("t3_nout", q.size(), N);
        check_frame("t3", 0, 0, t0 + LAT + 1, 10, 12);
        @(negedge clk) err_clr = 1'b1;
        @(negedge clk) err_clr = 1'b0;
        chk("t3_underrun_clr", underrun, 0);

        // 4: err_clr coincides with a new gap
        do_reset();
        run_samples("t4", N, 1, 5, 5, 1000, 5, t0);
        chk("t4_underrun_prio", underrun, 1);
        wait_idle("t4", 300);
        chk("t4_nout", q.size(), N);

        // 5: enable drops at sample 30
        do_reset();
        run_samples("t5", N + 16, 1, -1, -1, 30, -1, t0);
        chk("t5_in_ready_idle", bus.in_ready, 0);
        wait_idle("t5", 300);
        chk("t5_nout", q.size(), N);
        check_frame("t5", 0, 0, t0 + LAT + 1, -1, -1);
        chk("t5_frame_cnt", frame_cnt, 1);

        // 6: reset mid-frame
        do_reset();
        run_samples("t6", 20, 1, -1, -1, 1000, -1, t0);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_in_ready", bus.in_ready, 0);
        chk("t6_rst_underrun", underrun, 0);
        chk("t6_rst_core_din", core_din, 0);
        rst = 1'b0;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.out_valid || bus.out_data != '0) bad++;
        end
        chk("t6_quiet_cycles", bad, 0);
        chk("t6_nout_quiet", q.size(), 0);
        run_samples("t6f", N, 1, -1, -1, 1000, -1, t0);
        wait_idle("t6f", 300);
        chk("t6_nout", q.size(), N);
        check_frame("t6f", 0, 0, t0 + LAT + 1, -1, -1);
        chk("t6_frame_cnt", frame_cnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
